ina_reg_bank: RTL and testbench
===============================

INA_REG_BANK -- requirements
Module: ina_reg_bank

Interface
REQ-001 Parameter CFG_RST, default 16'h399F: configuration register reset value.
REQ-002 Parameter CAL_RST, default 16'h0000: calibration register reset value.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 wr_stb  in  1  one-cycle pulse; wr_ptr/wr_data valid, from the I2C slave after the data ACK.
REQ-006 wr_ptr  in  8  register pointer for the write.
REQ-007 wr_data  in  16  write data, MSB first as received on the bus.
REQ-008 rd_ptr  in  8  pointer currently selected by the I2C slave.
REQ-009 rd_stb  in  1  one-cycle pulse; a 16-bit read of rd_ptr has completed.
REQ-010 rd_data  out  16  combinational read mux of rd_ptr, driven onto the slave's data_out.
REQ-011 meas_valid  in  1  one-cycle pulse; new ADC sample present.
REQ-012 shunt_in  in  16  signed shunt-voltage sample.
REQ-013 bus_in  in  13  unsigned bus-voltage sample.
REQ-014 cnvr  out  1  conversion-ready flag.
REQ-015 ovf  out  1  math-overflow flag.

Function
REQ-016 Register map SHALL be: 0 CONFIG (RW), 1 SHUNT (RO), 2 BUS (RO) = {bus[12:0], 1'b0, cnvr, ovf}, 3 POWER (RO), 4 CURRENT (RO), 5 CALIB (RW, bit0 always reads 0).
REQ-017 Reads of pointers >5 SHALL return 16'h0000; writes to RO or undefined pointers SHALL be ignored.
REQ-018 Compute FSM SHALL have states IDLE, MUL_I, MUL_P, DONE; IDLE->MUL_I on a sample accepted, then one state per cycle, DONE->IDLE.
REQ-019 Entering MUL_I SHALL latch SHUNT, BUS, and a snapshot of CALIB; CALIB writes during computation SHALL affect only the next conversion.
REQ-020 MUL_I: CURRENT = (SHUNT * CALIB_snapshot) >>> 12, 32-bit signed product, saturated to the signed 16-bit range.
REQ-021 MUL_P: POWER = (|CURRENT| * BUS) >> 12, unsigned, saturated to 16'hFFFF.
REQ-022 DONE SHALL set cnvr; ovf SHALL be set in DONE if either saturation occurred; POWER/CURRENT update in MUL_P/MUL_I respectively.
REQ-023 Latency: meas_valid at cycle N -> cnvr high at cycle N+4 (IDLE sample / MUL_I / MUL_P / DONE registered).
REQ-024 meas_valid while FSM is not IDLE SHALL be dropped with no state change.
REQ-025 cnvr and ovf SHALL clear on rd_stb with rd_ptr==3 or on any CONFIG write; a set in the same cycle SHALL win.
REQ-026 CONFIG bit15 written 1 SHALL restore all registers and the FSM to reset values on the next cycle; bit15 always reads 0.
REQ-027 CALIB==0 SHALL yield CURRENT=POWER=0 and no ovf.

Reset
REQ-028 rst SHALL set CONFIG=CFG_RST, CALIB=CAL_RST, SHUNT=BUS=POWER=CURRENT=0, cnvr=ovf=0, FSM=IDLE, averaging accumulator=0.
REQ-029 rst mid-computation SHALL abort it; no partial result becomes visible.

Configuration
REQ-030 With INA_AVG_EN defined: CONFIG[11:9]=n selects accumulation of 2^n samples (1..128); the FSM leaves IDLE only when the count completes, using the arithmetic mean (accumulator >>> n); a CONFIG write clears the accumulator and count.
REQ-031 Without INA_AVG_EN: CONFIG[11:9] SHALL be stored and read back but ignored; every accepted sample starts a conversion.

Structure
REQ-032 A shared package SHALL hold register pointer constants, FSM state encodings, CFG_RST/CAL_RST defaults and field positions of CONFIG.
REQ-033 One sub-module, ina_sat_mul (signed multiply, shift, saturate, overflow flag), SHALL be instantiated for both MUL_I and MUL_P.

Verification
REQ-034 CALIB=16'h1000, shunt=16'd1000, bus=13'd4096 -> CURRENT=1000, POWER=1000, cnvr high at N+4, ovf=0.
REQ-035 CALIB=16'hFFFE, shunt=16'h7FFF -> CURRENT=16'h7FFF, ovf=1; read of ptr 3 -> cnvr=ovf=0.
REQ-036 Second meas_valid at N+1 and N+2 -> ignored; single conversion from first sample.
REQ-037 Write CONFIG=16'h8000 after loading CALIB=16'h2000 -> next cycle CONFIG=16'h399F, CALIB=0, rd_data for ptr 0 = 16'h399F.
REQ-038 INA_AVG_EN, n=2, shunts 100,200,300,400, CALIB=16'h1000 -> one conversion after fourth sample, SHUNT=250, CURRENT=250.
REQ-039 rd_stb ptr 3 coincident with DONE -> cnvr remains 1; ptr 9 reads 16'h0000.

Source files
------------

// File: rtl/ina_reg_bank_pkg.sv
// ina_reg_bank_pkg: register map, CONFIG fields, reset defaults and compute FSM states
package ina_reg_bank_pkg;
  localparam logic [7:0] P_CFG = 8'd0;
  localparam logic [7:0] P_SHUNT = 8'd1;
  localparam logic [7:0] P_BUS = 8'd2;
  localparam logic [7:0] P_POWER = 8'd3;
  localparam logic [7:0] P_CURRENT = 8'd4;
  localparam logic [7:0] P_CAL = 8'd5;
  localparam logic [15:0] CFG_RST_DEF = 16'h399F;
  localparam logic [15:0] CAL_RST_DEF = 16'h0000;
  localparam int CFG_RST_BIT = 15;
  localparam int CFG_AVG_LSB = 9;
  localparam int CFG_AVG_MSB = 11;
  typedef enum logic [1:0] {S_IDLE, S_MUL_I, S_MUL_P, S_DONE} state_t;
endpackage

// File: rtl/ina_sat_mul.sv
// ina_sat_mul: signed multiply, >>>12, saturate to signed or unsigned 16-bit with overflow flag
module ina_sat_mul (
  input  logic signed [16:0] i_a,
  input  logic signed [16:0] i_b,
  input  logic               i_uns,
  output logic        [15:0] o_p,
  output logic               o_ovf
);
  logic signed [33:0] w_prod;
  logic signed [21:0] w_sh;
  assign w_prod = i_a * i_b;
  assign w_sh = 22'(w_prod >>> 12);
  assign o_ovf = i_uns ? (w_sh > 22'sd65535) : (w_sh > 22'sd32767 || w_sh < -22'sd32768);
  assign o_p = !o_ovf ? w_sh[15:0] : i_uns ? 16'hFFFF : w_sh[21] ? 16'h8000 : 16'h7FFF;
endmodule

// File: rtl/ina_reg_bank.sv
// ina_reg_bank: INA-style register bank with current/power compute FSM
// Optional sample averaging enabled by defining INA_AVG_EN.
module ina_reg_bank
  import ina_reg_bank_pkg::*;
#(
  parameter logic [15:0] CFG_RST = CFG_RST_DEF,
  parameter logic [15:0] CAL_RST = CAL_RST_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_stb,
  input  logic        [7:0]  wr_ptr,
  input  logic        [15:0] wr_data,
  input  logic        [7:0]  rd_ptr,
  input  logic               rd_stb,
  output logic        [15:0] rd_data,
  input  logic               meas_valid,
  input  logic signed [15:0] shunt_in,
  input  logic        [12:0] bus_in,
  output logic               cnvr,
  output logic               ovf
);
  logic [15:0] r_cfg, r_cal, r_cal_snap, r_power;
  logic signed [15:0] r_shunt, r_current;
  logic [12:0] r_bus;
  logic r_cnvr, r_ovf, r_sat;
  state_t r_state;
  logic w_cfg_wr, w_srst, w_clr, w_start, w_ovf;
  logic [15:0] w_mean, w_abs, w_p;
  logic signed [16:0] w_a, w_b;
  assign w_cfg_wr = wr_stb && wr_ptr == P_CFG;
  assign w_srst = w_cfg_wr && wr_data[CFG_RST_BIT];
  assign w_clr = w_cfg_wr || (rd_stb && rd_ptr == P_POWER);
`ifdef INA_AVG_EN
  logic signed [22:0] r_acc, w_acc_n;
  logic [6:0] r_cnt;
  logic [2:0] w_n;
  logic w_last;
  assign w_n = r_cfg[CFG_AVG_MSB:CFG_AVG_LSB];
  assign w_acc_n = r_acc + shunt_in;
  assign w_last = r_cnt == ((7'd1 << w_n) - 7'd1);
  assign w_mean = 16'(w_acc_n >>> w_n);
  assign w_start = meas_valid && r_state == S_IDLE && w_last;
  always_ff @(posedge clk) begin
    if (rst || w_cfg_wr) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (meas_valid && r_state == S_IDLE) begin
      r_acc <= w_last ? '0 : w_acc_n;
      r_cnt <= w_last ? '0 : r_cnt + 7'd1;
    end
  end
`else
  assign w_mean = shunt_in;
  assign w_start = meas_valid && r_state == S_IDLE;
`endif
  // One multiplier serves both steps: signed current in MUL_I, unsigned power in MUL_P
  assign w_abs = r_current[15] ? 16'(-r_current) : r_current;
  assign w_a = r_state == S_MUL_P ? {1'b0, w_abs} : {r_shunt[15], r_shunt};
  assign w_b = r_state == S_MUL_P ? {4'b0, r_bus} : {1'b0, r_cal_snap};
  ina_sat_mul u_mul (.i_a(w_a), .i_b(w_b), .i_uns(r_state == S_MUL_P), .o_p(w_p), .o_ovf(w_ovf));
  always_ff @(posedge clk) begin
    if (rst || w_srst) begin
      r_cfg <= CFG_RST;
      r_cal <= CAL_RST;
      r_cal_snap <= '0;
      r_shunt <= '0;
      r_bus <= '0;
      r_power <= '0;
      r_current <= '0;
      r_cnvr <= 1'b0;
      r_ovf <= 1'b0;
      r_sat <= 1'b0;
      r_state <= S_IDLE;
    end else begin
      if (w_cfg_wr) r_cfg <= {1'b0, wr_data[14:0]};
      if (wr_stb && wr_ptr == P_CAL) r_cal <= {wr_data[15:1], 1'b0};
      r_cnvr <= r_state == S_DONE ? 1'b1 : w_clr ? 1'b0 : r_cnvr;
      r_ovf <= (r_state == S_DONE && r_sat) ? 1'b1 : w_clr ? 1'b0 : r_ovf;
      case (r_state)
        S_IDLE: if (w_start) begin
          r_shunt <= w_mean;
          r_bus <= bus_in;
          r_cal_snap <= r_cal;
          r_state <= S_MUL_I;
        end
        S_MUL_I: begin
          r_current <= w_p;
          r_sat <= w_ovf;
          r_state <= S_MUL_P;
        end
        S_MUL_P: begin
          r_power <= w_p;
          r_sat <= r_sat | w_ovf;
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  always_comb
    rd_data = rd_ptr == P_CFG ? r_cfg :
              rd_ptr == P_SHUNT ? r_shunt :
              rd_ptr == P_BUS ? {r_bus, 1'b0, r_cnvr, r_ovf} :
              rd_ptr == P_POWER ? r_power :
              rd_ptr == P_CURRENT ? r_current :
              rd_ptr == P_CAL ? r_cal : 16'h0000;
  assign cnvr = r_cnvr;
  assign ovf = r_ovf;
endmodule

// File: tb/tb_ina_reg_bank.sv
// tb_ina_reg_bank: directed self-checking bench for ina_reg_bank
module tb_ina_reg_bank;
  logic clk = 1'b0, rst = 1'b1, wr_stb = 1'b0, rd_stb = 1'b0, meas_valid = 1'b0;
  logic [7:0] wr_ptr = '0, rd_ptr = '0;
  logic [15:0] wr_data = '0, shunt_in = '0, rd_data;
  logic [12:0] bus_in = '0;
  logic cnvr, ovf;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  ina_reg_bank dut (
    .clk(clk), .rst(rst), .wr_stb(wr_stb), .wr_ptr(wr_ptr), .wr_data(wr_data),
    .rd_ptr(rd_ptr), .rd_stb(rd_stb), .rd_data(rd_data), .meas_valid(meas_valid),
    .shunt_in(shunt_in), .bus_in(bus_in), .cnvr(cnvr), .ovf(ovf)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic rdchk(input logic [7:0] p, input logic [15:0] exp, input string tag);
    rd_ptr = p;
    #1;
    check(tag, rd_data, exp);
  endtask
  task automatic wr(input logic [7:0] p, input logic [15:0] d);
    wr_stb = 1'b1;
    wr_ptr = p;
    wr_data = d;
    tick();
    wr_stb = 1'b0;
  endtask
  task automatic meas(input logic [15:0] s, input logic [12:0] b);
    meas_valid = 1'b1;
    shunt_in = s;
    bus_in = b;
    tick();
    meas_valid = 1'b0;
  endtask
  task automatic rd_clear();
    rd_ptr = 8'd3;
    rd_stb = 1'b1;
    tick();
    rd_stb = 1'b0;
  endtask
  initial begin
    tick(2);
    rst = 1'b0;
    check("rst_cnvr", cnvr, 0);
    check("rst_ovf", ovf, 0);
    rdchk(0, 16'h399F, "rst_cfg");
    rdchk(1, 0, "rst_shunt");
    rdchk(2, 0, "rst_bus");
    rdchk(3, 0, "rst_power");
    rdchk(4, 0, "rst_current");
    rdchk(5, 0, "rst_cal");
`ifdef INA_AVG_EN
    wr(0, 16'h319F);
`endif
    wr(5, 16'h1235);
    rdchk(5, 16'h1234, "cal_bit0");
    wr(5, 16'h1000);
    wr(1, 16'hBEEF);
    rdchk(1, 0, "ro_write_ignored");
    // basic conversion and latency
    meas(16'd1000, 13'd4096);
    tick(2);
    check("lat_n3_cnvr", cnvr, 0);
    tick();
    check("lat_n4_cnvr", cnvr, 1);
    check("basic_ovf", ovf, 0);
    rdchk(4, 16'd1000, "basic_current");
    rdchk(3, 16'd1000, "basic_power");
    rdchk(1, 16'd1000, "basic_shunt");
    rdchk(2, 16'h8002, "basic_bus_reg");
    rd_clear();
    check("rd3_clr_cnvr", cnvr, 0);
    // extra samples while busy are dropped; clear coincident with DONE loses
    meas_valid = 1'b1;
    shunt_in = 16'd2000;
    bus_in = 13'd4096;
    tick();
    shunt_in = 16'd500;
    tick(2);
    meas_valid = 1'b0;
    rd_ptr = 8'd3;
    rd_stb = 1'b1;
    tick();
    rd_stb = 1'b0;
    check("done_clr_cnvr", cnvr, 1);
    rdchk(4, 16'd2000, "drop_current");
    tick(4);
    rdchk(1, 16'd2000, "drop_shunt");
    rdchk(9, 16'h0000, "undef_ptr9");
    // positive saturation
    wr(5, 16'hFFFE);
    meas(16'h7FFF, 13'd4096);
    tick(3);
    rdchk(4, 16'h7FFF, "sat_current");
    rdchk(3, 16'h7FFF, "sat_power");
    check("sat_ovf", ovf, 1);
    rd_clear();
    check("sat_clr_cnvr", cnvr, 0);
    check("sat_clr_ovf", ovf, 0);
    // negative shunt: power uses magnitude
    wr(5, 16'h1000);
    meas(16'hFC18, 13'd4096);
    tick(3);
    rdchk(4, 16'hFC18, "neg_current");
    rdchk(3, 16'd1000, "neg_power");
    check("neg_ovf", ovf, 0);
    check("neg_cnvr", cnvr, 1);
    wr(0, 16'h399F);
    check("cfgwr_clr_cnvr", cnvr, 0);
    // zero calibration
    wr(5, 16'h0000);
    meas(16'h7FFF, 13'd8191);
    tick(3);
    rdchk(4, 0, "cal0_current");
    rdchk(3, 0, "cal0_power");
    check("cal0_ovf", ovf, 0);
    check("cal0_cnvr", cnvr, 1);
    // reset mid-computation
    wr(5, 16'h1000);
    meas(16'd3000, 13'd4096);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(3);
    check("abort_cnvr", cnvr, 0);
    rdchk(4, 0, "abort_current");
    rdchk(3, 0, "abort_power");
    // software reset via CONFIG bit15
    wr(5, 16'h2000);
    wr(0, 16'h1234);
    wr(0, 16'h8000);
    rdchk(0, 16'h399F, "srst_cfg");
    rdchk(5, 0, "srst_cal");
    // averaging field stored; behaviour depends on build
    wr(0, 16'h359F);
    rdchk(0, 16'h359F, "cfg_avg_readback");
    wr(5, 16'h1000);
`ifdef INA_AVG_EN
    meas(16'd100, 13'd4096);
    meas(16'd200, 13'd4096);
    meas(16'd300, 13'd4096);
    tick(4);
    check("avg_partial_cnvr", cnvr, 0);
    meas(16'd400, 13'd4096);
    tick(3);
    check("avg_cnvr", cnvr, 1);
    rdchk(1, 16'd250, "avg_shunt");
    rdchk(4, 16'd250, "avg_current");
`else
    meas(16'd100, 13'd4096);
    tick(3);
    check("noavg_cnvr", cnvr, 1);
    rdchk(1, 16'd100, "noavg_shunt");
    rdchk(4, 16'd100, "noavg_current");
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
